// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CPU/MMIO side, the TX byte FIFO and the
// UART transmitter. The slave modport is the FIFO itself; the master modport
// is whatever drives the enqueue side and consumes the dequeue side.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             flush;
  logic [WIDTH-1:0] enq_data;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] deq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  modport master (
    output flush, enq_data, enq_valid, deq_ready,
    input  enq_ready, deq_data, deq_valid, count, full, empty
  );

  modport slave (
    input  flush, enq_data, enq_valid, deq_ready,
    output enq_ready, deq_data, deq_valid, count, full, empty
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pointers carry an extra wrap bit so
// full/empty/count fall straight out of the two registered pointers.
// Optional feature macro: UART_TX_FIFO_BYPASS_EN -- when defined, a byte
// offered while the FIFO is empty and the transmitter is ready passes
// combinationally to the dequeue side without touching the pointers.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s;
  logic [AW:0]      rd_ptr_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic empty_s;
  logic full_s;
  logic enq_fire_s;
  logic wr_en_s;
  logic deq_fire_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                   (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // Enqueue depends only on registered fullness, never on deq_ready.
  assign enq_fire_s = bus.enq_valid && !full_s;
  assign deq_fire_s = !empty_s && bus.deq_ready;

`ifdef UART_TX_FIFO_BYPASS_EN
  logic bypass_s;
  // A byte that would land in an empty FIFO and be taken at once skips storage.
  assign bypass_s      = empty_s && bus.enq_valid && bus.deq_ready && !bus.flush;
  assign wr_en_s       = enq_fire_s && !bypass_s;
  assign bus.deq_valid = !empty_s || bypass_s;
  assign bus.deq_data  = bypass_s ? bus.enq_data : mem_r[rd_ptr_r[AW-1:0]];
`else
  assign wr_en_s       = enq_fire_s;
  assign bus.deq_valid = !empty_s;
  assign bus.deq_data  = mem_r[rd_ptr_r[AW-1:0]];
`endif

  assign bus.enq_ready = !full_s;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.count     = wr_ptr_r - rd_ptr_r;

  // Next-pointer selection; flush snaps the read pointer onto the post-write
  // write pointer so any same-cycle byte is dropped along with the rest.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (bus.flush) begin
      rd_ptr_nxt_s = wr_ptr_nxt_s;
    end else if (deq_fire_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Pointer registers, cleared asynchronously so reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= bus.enq_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=8, WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.enq_data  = 8'h00;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    step();

    // Burst fill 0x41..0x48 with the transmitter stalled.
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.enq_data = 8'(8'h41 + i);
      step();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_enq_ready", 32'(bus.enq_ready), 32'd0);
    chk("fill_empty", 32'(bus.empty), 32'd0);
    bus.enq_data = 8'h49;
    step();
    chk("ninth_count", 32'(bus.count), 32'd8);
    chk("ninth_head", 32'(bus.deq_data), 32'h41);

    // Drain; the first cycle still offers 0x49 while full and dequeuing.
    bus.deq_ready = 1'b1;
    #1;
    chk("drain_head", 32'(bus.deq_data), 32'h41);
    chk("drain_valid", 32'(bus.deq_valid), 32'd1);
    step();
    bus.enq_valid = 1'b0;
    chk("full_deq_no_enq", 32'(bus.count), 32'd7);
    for (int i = 1; i < 8; i++) begin
      chk("drain_valid", 32'(bus.deq_valid), 32'd1);
      chk("drain_data", 32'(bus.deq_data), 32'(8'h41 + i));
      step();
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);
    bus.deq_ready = 1'b0;

    // Enqueue five, dequeue two, leaving three queued.
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.enq_data = 8'(8'hA0 + i);
      exp_q.push_back(8'(8'hA0 + i));
      step();
    end
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("pre_wrap_data", 32'(bus.deq_data), 32'(exp_q.pop_front()));
      step();
    end
    bus.deq_ready = 1'b0;
    chk("pre_wrap_count", 32'(bus.count), 32'd3);

    // Twelve cycles of simultaneous enqueue and dequeue across the wrap.
    bus.enq_valid = 1'b1;
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.enq_data = 8'(i);
      exp_q.push_back(8'(i));
      chk("wrap_data", 32'(bus.deq_data), 32'(exp_q.pop_front()));
      step();
      chk("wrap_count", 32'(bus.count), 32'd3);
    end
    bus.deq_ready = 1'b0;
    bus.enq_data  = 8'h0C;
    step();
    bus.enq_valid = 1'b0;
    chk("pre_flush_count", 32'(bus.count), 32'd4);
    chk("pre_flush_head", 32'(bus.deq_data), 32'h09);

    // Flush with a same-cycle enqueue of 0x55 and dequeue request.
    bus.flush     = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_data  = 8'h55;
    bus.deq_ready = 1'b1;
    #1;
    chk("flush_enq_ready", 32'(bus.enq_ready), 32'd1);
    step();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_deq_valid", 32'(bus.deq_valid), 32'd0);
    bus.enq_valid = 1'b1;
    bus.enq_data  = 8'h77;
    step();
    bus.enq_valid = 1'b0;
    chk("post_flush_head", 32'(bus.deq_data), 32'h77);
    chk("post_flush_count", 32'(bus.count), 32'd1);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    chk("post_flush_empty", 32'(bus.empty), 32'd1);

    // Enqueue on empty with the transmitter ready.
    bus.enq_valid = 1'b1;
    bus.enq_data  = 8'h3C;
    bus.deq_ready = 1'b1;
    #1;
`ifdef UART_TX_FIFO_BYPASS_EN
    chk("bypass_valid", 32'(bus.deq_valid), 32'd1);
    chk("bypass_data", 32'(bus.deq_data), 32'h3C);
`else
    chk("no_fallthrough", 32'(bus.deq_valid), 32'd0);
`endif
    step();
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
`ifdef UART_TX_FIFO_BYPASS_EN
    chk("bypass_count", 32'(bus.count), 32'd0);
`else
    chk("latency_count", 32'(bus.count), 32'd1);
    chk("latency_valid", 32'(bus.deq_valid), 32'd1);
    chk("latency_data", 32'(bus.deq_data), 32'h3C);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
`endif
    chk("latency_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-cycle with three entries held.
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enq_data = 8'(8'h11 * (i + 1));
      step();
    end
    bus.enq_valid = 1'b0;
    chk("pre_areset_count", 32'(bus.count), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_empty", 32'(bus.empty), 32'd1);
    chk("areset_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("areset_enq_ready", 32'(bus.enq_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_areset_count", 32'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
